mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
Pipeline MEM stage, directly downstream of the EX/MEM register; consumes its MEM_* outputs.
- Holds the data memory and performs byte/halfword/word stores and loads with sign or zero extension.
- Resolves the branch-taken select for IF.
- Contains a debug dump sequencer that streams every memory word to the debug unit over a valid/ready handshake after halt.

Parameters:
NB_DATA, 32, data/address width
NB_ADDR, 7, word-address width (memory depth 2^NB_ADDR words)

Ports:
i_clock  in  1  system clock
i_reset  in  1  asynchronous, active-high reset
MEM_mem_read  in  1  load enable
MEM_mem_write  in  1  store enable
MEM_branch  in  1  branch instruction
MEM_zero  in  1  ALU zero flag
MEM_alu_result  in  NB_DATA  byte address
MEM_data_b  in  NB_DATA  store data
MEM_byte_en  in  1  byte access
MEM_halfword_en  in  1  halfword access
MEM_word_en  in  1  word access
MEM_unsigned  in  1  1 = zero-extend loads (LBU/LHU)
o_mem_data  out  NB_DATA  extended load data to WB
o_pcsrc  out  1  branch taken
o_misaligned  out  1  access violates alignment
i_dbg_dump_start  in  1  request memory dump
i_dbg_ready  in  1  debug consumer ready
o_dbg_valid  out  1  dump word valid
o_dbg_addr  out  NB_ADDR  word index of o_dbg_data
o_dbg_data  out  NB_DATA  dump word
o_dbg_done  out  1  dump complete

Behaviour:
Addressing
- Word index = MEM_alu_result[NB_ADDR+1:2]; offset = MEM_alu_result[1:0]. Upper bits are ignored, so addresses wrap.

Memory array
- Async reset clears all words to 0.
- Stores commit on posedge i_clock when MEM_mem_write=1, the access is aligned, and FSM=IDLE.
  - Byte store: writes lane `offset` (bits 8*offset+7:8*offset) with data_b[7:0].
  - Halfword store: writes lane offset[1] with data_b[15:0].
  - Word store: writes the full word.
  - Unaddressed lanes are preserved.
  - Enable priority: word > halfword > byte. If no enable is set, there is no write.

Loads
- Combinational from the array: the same lane selection as stores, extended per MEM_unsigned.
- o_mem_data=0 when MEM_mem_read=0 or the access is misaligned.
- A store and a load to the same word in the same cycle: the load returns the old data. The new data is visible after the edge.

Alignment
- o_misaligned = (mem_read|mem_write) & ((halfword & offset[0]) | (word & offset!=0)). Combinational.
- A misaligned store is suppressed.

Branch
- o_pcsrc = MEM_branch & MEM_zero, combinational.

Dump FSM (states IDLE, DUMP, DONE; ptr is an NB_ADDR counter)
- IDLE: on i_dbg_dump_start=1, ptr<=0 and go to DUMP.
- DUMP:
  - o_dbg_valid=1, o_dbg_addr=ptr, o_dbg_data=mem[ptr].
  - On valid&ready: if ptr = all-ones go to DONE, else ptr<=ptr+1.
  - Without ready, outputs hold stable.
- DONE: o_dbg_done=1, o_dbg_valid=0. Return to IDLE when i_dbg_dump_start=0.
- Start pulses in DUMP/DONE are ignored. Pipeline stores are blocked in DUMP/DONE.
- Reset mid-dump: FSM=IDLE, ptr=0, memory cleared.

Reset values
- o_dbg_valid=0, o_dbg_done=0, o_dbg_addr=0, o_dbg_data=0, o_mem_data=0.
- o_pcsrc and o_misaligned follow their inputs.

Decomposition:
- Shared package: FSM state encodings; access-size constants; NB_DATA/NB_ADDR defaults.
- One sub-module, data_memory: array, byte-lane write, async clear.
- The load extractor, alignment check, branch logic, and dump FSM stay in mem_stage.

Test Plan:
1. Word store 0xDEADBEEF to addr 0x10, then word load at 0x10 -> o_mem_data=0xDEADBEEF, o_misaligned=0.
2. Byte store 0x80 to addr 0x13, then byte load at 0x13 signed -> 0xFFFFFF80; unsigned -> 0x00000080; word load at 0x10 -> 0x80ADBEEF.
3. Halfword store 0x8001 at 0x22, then halfword load signed -> 0xFFFF8001; halfword store at 0x21 -> o_misaligned=1, memory unchanged, o_mem_data=0.
4. MEM_branch=1 with MEM_zero=1 -> o_pcsrc=1; with MEM_zero=0 -> 0; MEM_branch=0 -> 0.
5. Preload mem[0..3]=1..4, pulse dump_start, toggle i_dbg_ready 1,0,1... -> words 1,2,3,4,0... delivered in order with addr 0..127, held stable during stalls; o_dbg_done=1 after addr 127; a store attempted during DUMP is not committed.
6. Assert i_reset while ptr=50 in DUMP -> o_dbg_valid=0 immediately, FSM IDLE, mem[0] reads 0; a new dump restarts at addr 0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: default widths, byte-lane
// geometry, dump sequencer states and access-size decoding.
package mem_stage_pkg;

  localparam int unsigned NB_DATA_DEF = 32;
  localparam int unsigned NB_ADDR_DEF = 7;
  localparam int unsigned NB_BYTE     = 8;
  localparam int unsigned NB_HALF     = 2 * NB_BYTE;

  // Debug dump sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DUMP = 2'd1,
    ST_DONE = 2'd2
  } dump_state_e;

  // Resolved access size after applying enable priority
  typedef enum logic [1:0] {
    SZ_NONE = 2'd0,
    SZ_BYTE = 2'd1,
    SZ_HALF = 2'd2,
    SZ_WORD = 2'd3
  } access_size_e;

  // Word beats halfword beats byte; no enable means no access
  function automatic access_size_e decode_size(input logic word_en,
                                               input logic half_en,
                                               input logic byte_en);
    access_size_e sz;
    sz = SZ_NONE;
    if (word_en)      sz = SZ_WORD;
    else if (half_en) sz = SZ_HALF;
    else if (byte_en) sz = SZ_BYTE;
    return sz;
  endfunction

endpackage

// File: rtl/mem_stage_data_memory.sv
// Data memory array: 2^NB_ADDR words, byte-lane write strobes, asynchronous
// clear on reset, two combinational read ports (pipeline load, debug dump).
//   clk_i/rst_i   : clock, async active-high clear
//   we_i          : write enable (qualified by wstrb_i per lane)
//   waddr_i       : word index written
//   wdata_i       : lane-replicated write data
//   wstrb_i       : one bit per byte lane
//   raddr_a_i/rdata_a_o : pipeline read port
//   raddr_b_i/rdata_b_o : dump read port
module data_memory
  import mem_stage_pkg::*;
#(
  parameter int unsigned NB_DATA = NB_DATA_DEF,
  parameter int unsigned NB_ADDR = NB_ADDR_DEF
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       we_i,
  input  logic [NB_ADDR-1:0]         waddr_i,
  input  logic [NB_DATA-1:0]         wdata_i,
  input  logic [NB_DATA/NB_BYTE-1:0] wstrb_i,
  input  logic [NB_ADDR-1:0]         raddr_a_i,
  output logic [NB_DATA-1:0]         rdata_a_o,
  input  logic [NB_ADDR-1:0]         raddr_b_i,
  output logic [NB_DATA-1:0]         rdata_b_o
);

  localparam int unsigned DEPTH   = 2 ** NB_ADDR;
  localparam int unsigned NB_STRB = NB_DATA / NB_BYTE;

  logic [NB_DATA-1:0] mem_q [DEPTH];

  // Array storage with per-lane write; unstrobed lanes keep their contents
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned w = 0; w < DEPTH; w++) begin
        mem_q[NB_ADDR'(w)] <= '0;
      end
    end else if (we_i) begin
      for (int unsigned l = 0; l < NB_STRB; l++) begin
        if (wstrb_i[l]) begin
          mem_q[waddr_i][NB_BYTE*l +: NB_BYTE] <= wdata_i[NB_BYTE*l +: NB_BYTE];
        end
      end
    end
  end

  // Reads see pre-edge contents, so a same-cycle load returns old data
  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data memory access (byte/halfword/word stores, sign or
// zero extended loads), alignment check, branch-taken select, and a debug
// dump sequencer that streams every memory word after halt.
//   i_clock/i_reset        : clock, async active-high reset
//   MEM_*                  : EX/MEM register outputs (control, address, data)
//   o_mem_data             : extended load data to WB (combinational)
//   o_pcsrc                : branch taken (combinational)
//   o_misaligned           : alignment violation (combinational)
//   i_dbg_dump_start/ready : dump request and consumer handshake
//   o_dbg_valid/addr/data  : dump stream
//   o_dbg_done             : dump complete
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned NB_DATA = NB_DATA_DEF,
  parameter int unsigned NB_ADDR = NB_ADDR_DEF
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               MEM_mem_read,
  input  logic               MEM_mem_write,
  input  logic               MEM_branch,
  input  logic               MEM_zero,
  input  logic [NB_DATA-1:0] MEM_alu_result,
  input  logic [NB_DATA-1:0] MEM_data_b,
  input  logic               MEM_byte_en,
  input  logic               MEM_halfword_en,
  input  logic               MEM_word_en,
  input  logic               MEM_unsigned,
  output logic [NB_DATA-1:0] o_mem_data,
  output logic               o_pcsrc,
  output logic               o_misaligned,
  input  logic               i_dbg_dump_start,
  input  logic               i_dbg_ready,
  output logic               o_dbg_valid,
  output logic [NB_ADDR-1:0] o_dbg_addr,
  output logic [NB_DATA-1:0] o_dbg_data,
  output logic               o_dbg_done
);

  localparam int unsigned NB_STRB = NB_DATA / NB_BYTE;

  logic [NB_ADDR-1:0] word_idx;
  logic [1:0]         offset;
  access_size_e       size;
  logic               misaligned;
  logic               store_en;
  logic [NB_STRB-1:0] wstrb;
  logic [NB_DATA-1:0] wdata;
  logic [NB_DATA-1:0] rd_word;
  logic [NB_DATA-1:0] dump_word;
  logic [NB_BYTE-1:0] load_byte;
  logic [NB_HALF-1:0] load_half;
  logic               sx_byte;
  logic               sx_half;
  logic [NB_DATA-1:0] load_data;
  logic               unused_addr_bits;

  dump_state_e        state_q;
  logic [NB_ADDR-1:0] ptr_q;
  logic               dbg_valid_q;
  logic               dbg_done_q;

  // Address split; bits above the array wrap and are intentionally dropped
  assign word_idx         = MEM_alu_result[NB_ADDR+1:2];
  assign offset           = MEM_alu_result[1:0];
  assign unused_addr_bits = ^MEM_alu_result[NB_DATA-1:NB_ADDR+2];
  assign size             = decode_size(MEM_word_en, MEM_halfword_en, MEM_byte_en);

  // Alignment uses the raw enables, so an overlapping word enable still flags
  assign misaligned = (MEM_mem_read | MEM_mem_write) &
                      ((MEM_halfword_en & offset[0]) |
                       (MEM_word_en & (offset != 2'b00)));

  // Pipeline stores are locked out while the dump sequencer owns memory
  assign store_en = MEM_mem_write & ~misaligned & (state_q == ST_IDLE);

  // Byte-lane strobe and replicated write data
  always_comb begin
    wstrb = '0;
    wdata = MEM_data_b;
    case (size)
      SZ_WORD: wstrb = '1;
      SZ_HALF: begin
        wstrb = offset[1] ? NB_STRB'(4'b1100) : NB_STRB'(4'b0011);
        wdata = {2{MEM_data_b[NB_HALF-1:0]}};
      end
      SZ_BYTE: begin
        wstrb = NB_STRB'(1) << offset;
        wdata = {NB_STRB{MEM_data_b[NB_BYTE-1:0]}};
      end
      default: wstrb = '0;
    endcase
  end

  data_memory #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_ADDR)
  ) u_data_memory (
    .clk_i     (i_clock),
    .rst_i     (i_reset),
    .we_i      (store_en),
    .waddr_i   (word_idx),
    .wdata_i   (wdata),
    .wstrb_i   (wstrb),
    .raddr_a_i (word_idx),
    .rdata_a_o (rd_word),
    .raddr_b_i (ptr_q),
    .rdata_b_o (dump_word)
  );

  // Load lane extraction and sign/zero extension
  always_comb begin
    load_byte = rd_word[{offset, 3'b000} +: NB_BYTE];
    load_half = rd_word[{offset[1], 4'b0000} +: NB_HALF];
    sx_byte   = ~MEM_unsigned & load_byte[NB_BYTE-1];
    sx_half   = ~MEM_unsigned & load_half[NB_HALF-1];
    load_data = '0;
    if (MEM_mem_read && !misaligned) begin
      case (size)
        SZ_WORD: load_data = rd_word;
        SZ_HALF: load_data = {{(NB_DATA-NB_HALF){sx_half}}, load_half};
        SZ_BYTE: load_data = {{(NB_DATA-NB_BYTE){sx_byte}}, load_byte};
        default: load_data = '0;
      endcase
    end
  end

  assign o_mem_data   = load_data;
  assign o_misaligned = misaligned;
  assign o_pcsrc      = MEM_branch & MEM_zero;

  // Dump sequencer: walks ptr over every word, advancing on valid&ready
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      dbg_valid_q <= 1'b0;
      dbg_done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_dbg_dump_start) begin
            state_q     <= ST_DUMP;
            ptr_q       <= '0;
            dbg_valid_q <= 1'b1;
          end
        end
        ST_DUMP: begin
          if (i_dbg_ready) begin
            if (ptr_q == '1) begin
              state_q     <= ST_DONE;
              dbg_valid_q <= 1'b0;
              dbg_done_q  <= 1'b1;
            end else begin
              ptr_q <= ptr_q + NB_ADDR'(1);
            end
          end
        end
        ST_DONE: begin
          if (!i_dbg_dump_start) begin
            state_q    <= ST_IDLE;
            dbg_done_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          dbg_valid_q <= 1'b0;
          dbg_done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Memory is frozen during the dump, so data stays stable across stalls
  assign o_dbg_valid = dbg_valid_q;
  assign o_dbg_done  = dbg_done_q;
  assign o_dbg_addr  = ptr_q;
  assign o_dbg_data  = dbg_valid_q ? dump_word : '0;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed stores/loads against a bench
// memory model, branch select, dump streaming with stalls, reset mid-dump.
module tb_mem_stage;

  logic        i_clock;
  logic        i_reset;
  logic        MEM_mem_read;
  logic        MEM_mem_write;
  logic        MEM_branch;
  logic        MEM_zero;
  logic [31:0] MEM_alu_result;
  logic [31:0] MEM_data_b;
  logic        MEM_byte_en;
  logic        MEM_halfword_en;
  logic        MEM_word_en;
  logic        MEM_unsigned;
  logic [31:0] o_mem_data;
  logic        o_pcsrc;
  logic        o_misaligned;
  logic        i_dbg_dump_start;
  logic        i_dbg_ready;
  logic        o_dbg_valid;
  logic [6:0]  o_dbg_addr;
  logic [31:0] o_dbg_data;
  logic        o_dbg_done;

  mem_stage dut (
    .i_clock          (i_clock),
    .i_reset          (i_reset),
    .MEM_mem_read     (MEM_mem_read),
    .MEM_mem_write    (MEM_mem_write),
    .MEM_branch       (MEM_branch),
    .MEM_zero         (MEM_zero),
    .MEM_alu_result   (MEM_alu_result),
    .MEM_data_b       (MEM_data_b),
    .MEM_byte_en      (MEM_byte_en),
    .MEM_halfword_en  (MEM_halfword_en),
    .MEM_word_en      (MEM_word_en),
    .MEM_unsigned     (MEM_unsigned),
    .o_mem_data       (o_mem_data),
    .o_pcsrc          (o_pcsrc),
    .o_misaligned     (o_misaligned),
    .i_dbg_dump_start (i_dbg_dump_start),
    .i_dbg_ready      (i_dbg_ready),
    .o_dbg_valid      (o_dbg_valid),
    .o_dbg_addr       (o_dbg_addr),
    .o_dbg_data       (o_dbg_data),
    .o_dbg_done       (o_dbg_done)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [31:0] exp_q [$];
  string       tag_q [$];
  logic [31:0] model [128];

  task automatic push(input string tag, input logic [31:0] e);
    tag_q.push_back(tag);
    exp_q.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    logic [31:0] e;
    string t;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty: observed %h expected <none>", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", t, obs, e);
      end
    end
  endtask

  task automatic bus_idle();
    MEM_mem_read    = 1'b0;
    MEM_mem_write   = 1'b0;
    MEM_byte_en     = 1'b0;
    MEM_halfword_en = 1'b0;
    MEM_word_en     = 1'b0;
    MEM_unsigned    = 1'b0;
    MEM_alu_result  = '0;
    MEM_data_b      = '0;
  endtask

  task automatic set_size(input int sz);
    MEM_byte_en     = (sz == 0);
    MEM_halfword_en = (sz == 1);
    MEM_word_en     = (sz == 2);
  endtask

  // sz: 0 byte, 1 halfword, 2 word. Updates the model if aligned.
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input int sz);
    logic [6:0] idx;
    logic       bad;
    idx = a[8:2];
    bad = (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 2'b00);
    MEM_alu_result = a;
    MEM_data_b     = d;
    MEM_mem_write  = 1'b1;
    set_size(sz);
    @(posedge i_clock); #1;
    bus_idle();
    if (!bad) begin
      case (sz)
        2: model[idx] = d;
        1: if (a[1]) model[idx][31:16] = d[15:0]; else model[idx][15:0] = d[15:0];
        default: begin
          case (a[1:0])
            2'd0: model[idx][7:0]   = d[7:0];
            2'd1: model[idx][15:8]  = d[7:0];
            2'd2: model[idx][23:16] = d[7:0];
            default: model[idx][31:24] = d[7:0];
          endcase
        end
      endcase
    end
  endtask

  task automatic do_load(input string tag, input logic [31:0] a, input int sz,
                         input logic uns, input logic [31:0] e);
    MEM_alu_result = a;
    MEM_mem_read   = 1'b1;
    MEM_unsigned   = uns;
    set_size(sz);
    push(tag, e);
    @(negedge i_clock);
    chk(o_mem_data);
    @(posedge i_clock); #1;
    bus_idle();
  endtask

  initial begin
    int  exp_idx;
    int  cyc;
    bit  done_seen;
    bit  hit;

    for (int i = 0; i < 128; i++) model[i] = '0;
    bus_idle();
    MEM_branch       = 1'b0;
    MEM_zero         = 1'b0;
    i_dbg_dump_start = 1'b0;
    i_dbg_ready      = 1'b0;
    i_reset          = 1'b1;

    // Reset state
    #2;
    push("rst_valid", 32'd0);    chk(32'(o_dbg_valid));
    push("rst_done", 32'd0);     chk(32'(o_dbg_done));
    push("rst_addr", 32'd0);     chk(32'(o_dbg_addr));
    push("rst_data", 32'd0);     chk(o_dbg_data);
    push("rst_mem_data", 32'd0); chk(o_mem_data);
    @(posedge i_clock); @(posedge i_clock); #1;
    i_reset = 1'b0;

    // Word store / load
    do_store(32'h10, 32'hDEADBEEF, 2);
    MEM_alu_result = 32'h10; MEM_mem_read = 1'b1; set_size(2);
    push("t1_misaligned", 32'd0);
    @(negedge i_clock); chk(32'(o_misaligned));
    bus_idle();
    do_load("t1_word_load", 32'h10, 2, 1'b0, 32'hDEADBEEF);

    // Byte store, signed and unsigned byte loads, merged word
    do_store(32'h13, 32'h00000080, 0);
    do_load("t2_lb", 32'h13, 0, 1'b0, 32'hFFFFFF80);
    do_load("t2_lbu", 32'h13, 0, 1'b1, 32'h00000080);
    do_load("t2_word", 32'h10, 2, 1'b0, 32'h80ADBEEF);
    do_store(32'h11, 32'h0000007F, 0);
    do_load("t2_lb_pos", 32'h11, 0, 1'b0, 32'h0000007F);

    // Halfword store/load and misaligned halfword
    do_store(32'h22, 32'h00008001, 1);
    do_load("t3_lh", 32'h22, 1, 1'b0, 32'hFFFF8001);
    do_load("t3_lhu", 32'h22, 1, 1'b1, 32'h00008001);
    MEM_alu_result = 32'h21; MEM_data_b = 32'h1234; MEM_mem_write = 1'b1; set_size(1);
    push("t3_misaligned_st", 32'd1);
    @(negedge i_clock); chk(32'(o_misaligned));
    @(posedge i_clock); #1; bus_idle();
    MEM_alu_result = 32'h21; MEM_mem_read = 1'b1; set_size(1);
    push("t3_misaligned_ld", 32'd1);
    push("t3_misaligned_data", 32'd0);
    @(negedge i_clock); chk(32'(o_misaligned)); chk(o_mem_data);
    @(posedge i_clock); #1; bus_idle();
    do_load("t3_word_unchanged", 32'h20, 2, 1'b0, 32'h80010000);
    MEM_alu_result = 32'h12; MEM_mem_read = 1'b1; set_size(2);
    push("t3_word_misaligned", 32'd1);
    @(negedge i_clock); chk(32'(o_misaligned));
    @(posedge i_clock); #1; bus_idle();

    // Same-cycle store and load to one word returns old data
    MEM_alu_result = 32'h10; MEM_data_b = 32'h11111111;
    MEM_mem_write = 1'b1; MEM_mem_read = 1'b1; set_size(2);
    push("raw_old", model[4]);
    @(negedge i_clock); chk(o_mem_data);
    @(posedge i_clock); #1;
    model[4] = 32'h11111111;
    MEM_mem_write = 1'b0;
    push("raw_new", 32'h11111111);
    @(negedge i_clock); chk(o_mem_data);
    @(posedge i_clock); #1; bus_idle();

    // Address wrap: bits above the array are ignored
    do_store(32'h204, 32'hCAFEF00D, 2);
    do_load("wrap", 32'h4, 2, 1'b0, 32'hCAFEF00D);

    // Branch select
    MEM_branch = 1'b1; MEM_zero = 1'b1; push("pcsrc_11", 32'd1); #1; chk(32'(o_pcsrc));
    MEM_zero = 1'b0;                    push("pcsrc_10", 32'd0); #1; chk(32'(o_pcsrc));
    MEM_branch = 1'b0; MEM_zero = 1'b1; push("pcsrc_01", 32'd0); #1; chk(32'(o_pcsrc));
    MEM_zero = 1'b0;
    @(posedge i_clock); #1;

    // Dump with alternating ready, a blocked store and an ignored start pulse
    do_store(32'h0, 32'd1, 2);
    do_store(32'h4, 32'd2, 2);
    do_store(32'h8, 32'd3, 2);
    do_store(32'hC, 32'd4, 2);
    i_dbg_dump_start = 1'b1;
    @(posedge i_clock); #1;
    i_dbg_dump_start = 1'b0;
    exp_idx = 0; cyc = 0; done_seen = 1'b0;
    while (!done_seen && cyc < 1000) begin
      i_dbg_ready = (cyc % 2 == 0);
      if (cyc == 3) begin
        MEM_alu_result = 32'h40; MEM_data_b = 32'hBAD0BAD0;
        MEM_mem_write = 1'b1; set_size(2);
      end else begin
        bus_idle();
      end
      i_dbg_dump_start = (cyc == 10);
      @(negedge i_clock);
      if (exp_idx < 128) begin
        push("dump_valid", 32'd1);          chk(32'(o_dbg_valid));
        push("dump_addr", 32'(exp_idx));    chk(32'(o_dbg_addr));
        push("dump_data", model[exp_idx]);  chk(o_dbg_data);
        if (i_dbg_ready) exp_idx++;
      end else begin
        push("done_flag", 32'd1);  chk(32'(o_dbg_done));
        push("done_valid", 32'd0); chk(32'(o_dbg_valid));
        done_seen = 1'b1;
      end
      @(posedge i_clock); #1;
      cyc++;
    end
    if (!done_seen) begin
      n_vec++; n_err++;
      $error("FAIL dump_timeout: observed %0d words expected 128", exp_idx);
    end
    i_dbg_ready = 1'b0;
    bus_idle();
    push("done_cleared", 32'd0);
    @(negedge i_clock); chk(32'(o_dbg_done));
    @(posedge i_clock); #1;
    do_load("dump_store_blocked", 32'h40, 2, 1'b0, 32'h0);

    // Reset in the middle of a dump
    i_dbg_ready = 1'b1;
    i_dbg_dump_start = 1'b1;
    @(posedge i_clock); #1;
    i_dbg_dump_start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge i_clock);
      if (o_dbg_valid && o_dbg_addr == 7'd50) hit = 1'b1;
    end
    push("mid_reach_50", 32'd1); chk(32'(hit));
    i_reset = 1'b1;
    #1;
    push("mid_rst_valid", 32'd0); chk(32'(o_dbg_valid));
    push("mid_rst_addr", 32'd0);  chk(32'(o_dbg_addr));
    push("mid_rst_done", 32'd0);  chk(32'(o_dbg_done));
    i_dbg_ready = 1'b0;
    @(posedge i_clock); #1;
    i_reset = 1'b0;
    for (int i = 0; i < 128; i++) model[i] = '0;
    do_load("mid_rst_mem0", 32'h0, 2, 1'b0, 32'h0);
    i_dbg_dump_start = 1'b1;
    @(posedge i_clock); #1;
    i_dbg_dump_start = 1'b0;
    @(negedge i_clock);
    push("restart_valid", 32'd1); chk(32'(o_dbg_valid));
    push("restart_addr", 32'd0);  chk(32'(o_dbg_addr));
    push("restart_data", 32'd0);  chk(o_dbg_data);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
